seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter GAP, default 1, meaning the number of idle cycles inserted between repeated frames (0..15).
REQ-002 SHALL have port ck, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rs, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port start, input, 1, transmit request, sampled only in IDLE.
REQ-005 SHALL have port word, input, 8, parallel frame bits; the frame is word[len:0].
REQ-006 SHALL have port len, input, 3, frame length minus one (0 gives 1 bit, 7 gives 8 bits).
REQ-007 SHALL have port rep, input, 2, extra repeats (0 gives 1 frame, 3 gives 4 frames).
REQ-008 SHALL have port data, output, 1, serial bit stream that feeds the pattern detector data input.
REQ-009 SHALL have port dvalid, output, 1, high when data carries a frame or parity bit.
REQ-010 SHALL have port busy, output, 1, high in SHIFT, GAP and PAR.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, SHIFT, GAP, PAR (configuration-dependent) and DONE, with all outputs driven from registers (Moore).
REQ-013 In IDLE, start=1 at edge k SHALL latch word, len and rep, load the bit counter with len, and enter SHIFT, so the first bit appears on data in cycle k+1.
REQ-014 SHIFT SHALL emit one bit per cycle, MSB-first: word[len], word[len-1], ..., word[0], with dvalid=1 and busy=1.
REQ-015 After bit 0, SHALL go to PAR if configured; otherwise, if repeats remain, to GAP (GAP>0) or directly to SHIFT (GAP=0); otherwise to DONE.
REQ-016 Each new frame SHALL re-send the latched word and len, and SHALL decrement the repeat counter once per completed frame.
REQ-017 GAP SHALL last exactly GAP cycles, with data=0, dvalid=0 and busy=1.
REQ-018 DONE SHALL last one cycle with done=1, busy=0, dvalid=0 and data=0, then SHALL return to IDLE.
REQ-019 start SHALL be ignored in SHIFT, GAP, PAR and DONE; a held start SHALL begin a new transfer only on the first IDLE cycle after DONE.
REQ-020 Changes to word, len or rep during a transfer SHALL have no effect on that transfer.
REQ-021 In IDLE, data, dvalid, busy and done SHALL all be 0.

Reset
REQ-022 rs=1 at any edge, including mid-frame, SHALL force IDLE and clear the counters and the shift register.
REQ-023 In the cycle after that edge, data, dvalid, busy and done SHALL all be 0.
REQ-024 rs SHALL take priority over start in the same cycle.
REQ-025 No frame SHALL resume after rs is released; a new start is required.

Configuration
REQ-026 The feature SHALL be controlled by the macro SEQ_PATTERN_TX_PARITY_EN.
REQ-027 With SEQ_PATTERN_TX_PARITY_EN defined, each frame SHALL be followed by one PAR cycle in which data equals the XOR of the frame bits (even parity), dvalid=1 and busy=1; GAP or DONE follows that cycle.
REQ-028 With the macro undefined, PAR logic SHALL be absent and frames SHALL be sent back-to-back per REQ-015.

Verification
REQ-029 word=0x0C, len=3, rep=0, start pulse -> data 1,1,0,0 with dvalid=1 in cycles 1-4, done=1 in cycle 5, then IDLE (parity build: PAR bit 0 in cycle 5, done in cycle 6).
REQ-030 word=0x0B, len=3, rep=2, GAP=1, no parity -> 1011, one gap, 1011, one gap, 1011; exactly one done pulse, in cycle 15.
REQ-031 start held at 1 for 20 cycles with len=1, rep=0 -> no restart while busy; a new transfer begins on the IDLE cycle after DONE.
REQ-032 rs=1 during the third bit of an 8-bit frame -> next cycle all outputs 0 and state IDLE; no further dvalid until a new start.
REQ-033 word=0xA5, len=7 -> data 1,0,1,0,0,1,0,1; parity build adds PAR bit 0.
REQ-034 word=0x01, len=0, rep=3, GAP=0 -> data 1,1,1,1 on consecutive cycles, then done.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sends word[len:0] MSB-first, repeated rep+1 times with GAP idle cycles.
// Optional even-parity bit after each frame when SEQ_PATTERN_TX_PARITY_EN is defined.
module seq_pattern_tx #(
    parameter int GAP = 1
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       start,
    input  logic [7:0] word,
    input  logic [2:0] len,
    input  logic [1:0] rep,
    output logic       data,
    output logic       dvalid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
`ifdef SEQ_PATTERN_TX_PARITY_EN
        S_PAR,
`endif
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] word_q, word_d;
    logic [2:0] len_q, len_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] rep_q, rep_d;
    logic [3:0] gap_q, gap_d;
    logic       data_q, data_d;
    logic       dvalid_q, dvalid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       frame_end;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    function automatic logic frame_par(input logic [7:0] w, input logic [2:0] l);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i <= int'(l)) p = p ^ w[i];
        end
        return p;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        len_d     = len_q;
        bit_d     = bit_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        frame_end = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_d  = word;
                    len_d   = len;
                    rep_d   = rep;
                    bit_d   = len;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_q != 3'd0) begin
                    bit_d = bit_q - 3'd1;
                end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    state_d = S_PAR;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            S_PAR: frame_end = 1'b1;
`endif
            S_GAP: begin
                if (gap_q <= 4'd1) begin
                    state_d = S_SHIFT;
                    bit_d   = len_q;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // One frame finished: either start the next repeat or wrap up.
        if (frame_end) begin
            if (rep_q != 2'd0) begin
                rep_d = rep_q - 2'd1;
                bit_d = len_q;
                if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = 4'(GAP);
                end else begin
                    state_d = S_SHIFT;
                end
            end else begin
                state_d = S_DONE;
            end
        end

        data_d   = 1'b0;
        dvalid_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            S_SHIFT: begin
                data_d   = word_d[bit_d];
                dvalid_d = 1'b1;
                busy_d   = 1'b1;
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            S_PAR: begin
                data_d   = frame_par(word_d, len_d);
                dvalid_d = 1'b1;
                busy_d   = 1'b1;
            end
`endif
            S_GAP:   busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rs) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            len_q    <= '0;
            bit_q    <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            data_q   <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            len_q    <= len_d;
            bit_q    <= bit_d;
            rep_q    <= rep_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign data   = data_q;
    assign dvalid = dvalid_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: three GAP variants checked cycle by cycle
// against a queue-based model of the expected output stream.
module tb_seq_pattern_tx;

    typedef logic [3:0] q_t[$];

    logic       ck = 1'b0;
    logic       rs = 1'b1;
    logic       start = 1'b0;
    logic [7:0] word = '0;
    logic [2:0] len = '0;
    logic [1:0] rep = '0;

    logic data1, dvalid1, busy1, done1;
    logic data0, dvalid0, busy0, done0;
    logic data3, dvalid3, busy3, done3;

    int compared = 0;
    int failed = 0;

    always #5 ck = ~ck;

    seq_pattern_tx #(.GAP(1)) u_g1 (
        .ck(ck), .rs(rs), .start(start), .word(word), .len(len), .rep(rep),
        .data(data1), .dvalid(dvalid1), .busy(busy1), .done(done1)
    );
    seq_pattern_tx #(.GAP(0)) u_g0 (
        .ck(ck), .rs(rs), .start(start), .word(word), .len(len), .rep(rep),
        .data(data0), .dvalid(dvalid0), .busy(busy0), .done(done0)
    );
    seq_pattern_tx #(.GAP(3)) u_g3 (
        .ck(ck), .rs(rs), .start(start), .word(word), .len(len), .rep(rep),
        .data(data3), .dvalid(dvalid3), .busy(busy3), .done(done3)
    );

    q_t   e1, e0, e3;
    logic idle1 = 1'b1, idle0 = 1'b1, idle3 = 1'b1;
    logic [3:0] x;

    // Expected per-cycle {data,dvalid,busy,done} for one accepted transfer.
    function automatic q_t build(input int gap, input logic [7:0] w,
                                 input logic [2:0] l, input logic [1:0] r);
        q_t q;
        for (int f = 0; f <= int'(r); f++) begin
            for (int i = int'(l); i >= 0; i--) q.push_back({w[i], 3'b110});
`ifdef SEQ_PATTERN_TX_PARITY_EN
            q.push_back({^(w & 8'((9'd2 << l) - 9'd1)), 3'b110});
`endif
            if (f < int'(r)) repeat (gap) q.push_back(4'b0010);
        end
        q.push_back(4'b0001);
        return q;
    endfunction

    task automatic cmp(input string tag, input logic [3:0] o, input logic [3:0] e);
        compared++;
        assert (o === e) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic step(input string tag);
        @(posedge ck);
        if (rs) begin
            e1.delete(); e0.delete(); e3.delete();
        end else if (start) begin
            if (idle1) e1 = build(1, word, len, rep);
            if (idle0) e0 = build(0, word, len, rep);
            if (idle3) e3 = build(3, word, len, rep);
        end
        #1;
        if (e1.size() > 0) begin x = e1.pop_front(); idle1 = 1'b0; end
        else begin x = 4'b0; idle1 = 1'b1; end
        cmp({tag, "/g1"}, {data1, dvalid1, busy1, done1}, x);
        if (e0.size() > 0) begin x = e0.pop_front(); idle0 = 1'b0; end
        else begin x = 4'b0; idle0 = 1'b1; end
        cmp({tag, "/g0"}, {data0, dvalid0, busy0, done0}, x);
        if (e3.size() > 0) begin x = e3.pop_front(); idle3 = 1'b0; end
        else begin x = 4'b0; idle3 = 1'b1; end
        cmp({tag, "/g3"}, {data3, dvalid3, busy3, done3}, x);
    endtask

    task automatic go(input logic [7:0] w, input logic [2:0] l, input logic [1:0] r);
        word = w; len = l; rep = r; start = 1'b1;
        step("accept");
        start = 1'b0;
    endtask

    logic [7:0] cap;

    initial begin
        rs = 1'b1;
        step("reset");
        step("reset");
        rs = 1'b0;
        step("idle");

        go(8'h0C, 3'd3, 2'd0);
        repeat (8) step("w0c");

        go(8'h0B, 3'd3, 2'd2);
        repeat (20) step("w0b_rep");

        word = 8'h02; len = 3'd1; rep = 2'd0; start = 1'b1;
        repeat (20) step("held_start");
        start = 1'b0;
        repeat (10) step("held_end");

        go(8'hA5, 3'd7, 2'd0);
        step("bit2");
        step("bit3");
        rs = 1'b1;
        step("mid_rst");
        rs = 1'b0;
        repeat (12) step("post_rst");

        go(8'hA5, 3'd7, 2'd0);
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            cap = {cap[6:0], data1};
            step("wa5");
        end
        compared++;
        assert (cap === 8'hA5) else begin
            failed++;
            $error("FAIL wa5_serial observed=%h expected=%h", cap, 8'hA5);
        end
        repeat (6) step("wa5_tail");

        go(8'h01, 3'd0, 2'd3);
        repeat (16) step("w01_rep");

        for (int n = 0; n < 1500; n++) begin
            start = ($urandom_range(0, 3) == 0);
            rs    = ($urandom_range(0, 63) == 0);
            word  = 8'($urandom);
            len   = 3'($urandom);
            rep   = 2'($urandom);
            step("rand");
        end
        rs = 1'b0; start = 1'b0;
        repeat (40) step("drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
